// File: rtl/vedic8_multiplier.sv
// Two-stage unsigned 8x8 -> 16 multiplier built on the Urdhva-Tiryagbhyam
// scheme. Ports: clk, rst_n, in_valid, a, b -> c (product), out_valid.
module vedic8_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] c,
  output logic        out_valid
);

  function automatic logic [1:0] fa(
    input logic x,
    input logic y,
    input logic ci
  );
    fa = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  function automatic logic [7:0] add8(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic       cy;
    logic [1:0] r;
    add8 = '0;
    cy   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r       = fa(x[i], y[i], cy);
      add8[i] = r[0];
      cy      = r[1];
    end
  endfunction

  function automatic logic [11:0] add12(
    input logic [11:0] x,
    input logic [11:0] y
  );
    logic       cy;
    logic [1:0] r;
    add12 = '0;
    cy    = 1'b0;
    for (int i = 0; i < 12; i++) begin
      r        = fa(x[i], y[i], cy);
      add12[i] = r[0];
      cy       = r[1];
    end
  endfunction

  // 2x2 cell: the cross terms can both be 1, producing a carry k
  // into the weight-2 column.
  function automatic logic [3:0] mul2(
    input logic [1:0] x,
    input logic [1:0] y
  );
    logic t0, t1, k, hh;
    t0   = x[1] & y[0];
    t1   = x[0] & y[1];
    k    = t0 & t1;
    hh   = x[1] & y[1];
    mul2 = {hh & k, hh ^ k, t0 ^ t1, x[0] & y[0]};
  endfunction

  function automatic logic [7:0] mul4(
    input logic [3:0] x,
    input logic [3:0] y
  );
    logic [3:0] lo, m1, m2, hi;
    logic [7:0] s1, s2;
    lo   = mul2(x[1:0], y[1:0]);
    m1   = mul2(x[3:2], y[1:0]);
    m2   = mul2(x[1:0], y[3:2]);
    hi   = mul2(x[3:2], y[3:2]);
    s1   = add8({4'b0, lo}, {2'b0, m1, 2'b0});
    s2   = add8(s1, {2'b0, m2, 2'b0});
    mul4 = add8(s2, {hi, 4'b0});
  endfunction

  logic [7:0]  a_q, b_q;
  logic        v1_q;
  logic [15:0] c_q, c_d;
  logic        ov_q;

  logic [7:0]  q0, q1, q2, q3;
  logic [7:0]  t1;
  logic [11:0] t2, t3;

  always_comb begin
    q0  = mul4(a_q[3:0], b_q[3:0]);
    q1  = mul4(a_q[7:4], b_q[3:0]);
    q2  = mul4(a_q[3:0], b_q[7:4]);
    q3  = mul4(a_q[7:4], b_q[7:4]);
    t1  = add8({4'b0, q0[7:4]}, q1);
    t2  = add12({4'b0, q2}, {q3, 4'b0});
    t3  = add12({4'b0, t1}, t2);
    c_d = {t3, q0[3:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      v1_q <= 1'b0;
      c_q  <= '0;
      ov_q <= 1'b0;
    end else begin
      a_q  <= a;
      b_q  <= b;
      v1_q <= in_valid;
      c_q  <= c_d;
      ov_q <= v1_q;
    end
  end

  assign c         = c_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_vedic8_multiplier.sv
// Bench for vedic8_multiplier: random and directed stimulus against
// a plain a*b model with a 2-cycle history queue.
module tb_vedic8_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] c;
  logic        out_valid;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          v;
    logic [15:0] p;
  } exp_t;

  exp_t hist[$];

  vedic8_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one operand pair, advance one edge, and hand back the
  // expectation for what c/out_valid must show now (if any).
  task automatic tick(
    input  bit          v,
    input  logic [7:0]  aa,
    input  logic [7:0]  bb,
    output bit          have,
    output bit          ev,
    output logic [15:0] ec
  );
    exp_t e;
    exp_t o;
    in_valid = v;
    a        = aa;
    b        = bb;
    e.v      = v;
    e.p      = {8'b0, aa} * {8'b0, bb};
    hist.push_back(e);
    @(posedge clk);
    #1;
    have = 1'b0;
    ev   = 1'b0;
    ec   = '0;
    if (hist.size() == 2) begin
      o    = hist.pop_front();
      have = 1'b1;
      ev   = o.v;
      ec   = o.p;
    end
  endtask

  task automatic test_reset();
    bit          h, ev;
    logic [15:0] ec;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'($urandom);
      a        = 8'($urandom);
      b        = 8'($urandom);
      @(posedge clk);
      #1;
      n_cmp++;
      if (c !== 16'h0 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: c=%h ov=%b want c=0000 ov=0",
                 c, out_valid);
      end
    end
    rst_n = 1'b1;
    hist.delete();
    tick(1'b1, 8'hFF, 8'hFF, h, ev, ec);
    tick(1'b0, 8'h00, 8'h00, h, ev, ec);
    n_cmp++;
    if (out_valid !== 1'b1 || c !== 16'hFE01) begin
      n_err++;
      $display("FAIL reset_release_ff: c=%h ov=%b want c=fe01 ov=1",
               c, out_valid);
    end
  endtask

  task automatic test_corners();
    logic [7:0]  ta[5];
    logic [7:0]  tb_[5];
    bit          h, ev;
    logic [15:0] ec;
    ta  = '{8'h00, 8'h01, 8'h0F, 8'h80, 8'hFF};
    tb_ = '{8'h00, 8'hFF, 8'hF0, 8'h02, 8'hFF};
    for (int i = 0; i < 7; i++) begin
      if (i < 5) tick(1'b1, ta[i], tb_[i], h, ev, ec);
      else tick(1'b0, 8'($urandom), 8'($urandom), h, ev, ec);
      if (h) begin
        n_cmp++;
        if (out_valid !== ev || (ev && c !== ec)) begin
          n_err++;
          $display("FAIL corner: c=%h ov=%b want c=%h ov=%b",
                   c, out_valid, ec, ev);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ta[3];
    logic [7:0]  tb_[3];
    logic [15:0] want[3];
    bit          h, ev;
    logic [15:0] ec;
    int          k;
    ta   = '{8'd3, 8'd12, 8'd200};
    tb_  = '{8'd5, 8'd12, 8'd7};
    want = '{16'd15, 16'd144, 16'd1400};
    k    = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) tick(1'b1, ta[i], tb_[i], h, ev, ec);
      else tick(1'b0, 8'h00, 8'h00, h, ev, ec);
      if (h && k < 3) begin
        if (ev) begin
          n_cmp++;
          if (out_valid !== 1'b1 || c !== want[k]) begin
            n_err++;
            $display("FAIL stream%0d: c=%0d ov=%b want c=%0d ov=1",
                     k, c, out_valid, want[k]);
          end
          k++;
        end
      end
    end
    for (int i = 0; i < 40; i++) begin
      tick(1'($urandom), 8'($urandom), 8'($urandom), h, ev, ec);
      if (h) begin
        n_cmp++;
        if (out_valid !== ev || (ev && c !== ec)) begin
          n_err++;
          $display("FAIL rand_stream: c=%h ov=%b want c=%h ov=%b",
                   c, out_valid, ec, ev);
        end
      end
    end
  endtask

  task automatic test_bubble();
    bit          pat[5];
    bit          h, ev;
    logic [15:0] ec;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      tick(pat[i], 8'($urandom), 8'($urandom), h, ev, ec);
      if (h) begin
        n_cmp++;
        if (out_valid !== ev || (ev && c !== ec)) begin
          n_err++;
          $display("FAIL bubble: c=%h ov=%b want c=%h ov=%b",
                   c, out_valid, ec, ev);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bit          h, ev;
    logic [15:0] ec;
    tick(1'b1, 8'd77, 8'd91, h, ev, ec);
    tick(1'b1, 8'd250, 8'd3, h, ev, ec);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (c !== 16'h0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: c=%h ov=%b want c=0000 ov=0",
               c, out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hist.delete();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 8'($urandom), 8'($urandom), h, ev, ec);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_idle: ov=%b want ov=0", out_valid);
      end
    end
  endtask

  task automatic test_exhaustive();
    bit          h, ev;
    logic [15:0] ec;
    int          bad;
    bad = 0;
    for (int i = 0; i < 65538; i++) begin
      if (i < 65536) tick(1'b1, 8'(i >> 8), 8'(i), h, ev, ec);
      else tick(1'b0, 8'h00, 8'h00, h, ev, ec);
      if (h) begin
        n_cmp++;
        if (out_valid !== ev || (ev && c !== ec)) begin
          n_err++;
          if (bad < 10)
            $display("FAIL exhaustive: c=%h ov=%b want c=%h ov=%b",
                     c, out_valid, ec, ev);
          bad++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_back_to_back();
    test_bubble();
    test_async_reset();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vedic8_multiplier.md
Name: vedic8_multiplier

Overview:
- Unsigned 8x8 multiplier producing a 16-bit product, built structurally on the Urdhva-Tiryagbhyam (Vedic) scheme: 2x2 -> 4x4 -> 8x8 partial-product blocks combined by adders.
- Operands and product are registered, giving a two-stage pipeline that accepts one operand pair per clock.
- Sits in the arithmetic datapath as a drop-in fixed-latency multiplier.

Parameters:
- None. Width is fixed at 8x8 -> 16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  a/b carry a new operand pair this cycle.
- a  input  8  multiplicand, unsigned.
- b  input  8  multiplier, unsigned.
- c  output  16  product a*b, unsigned, registered.
- out_valid  output  1  c holds a valid product this cycle.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, takes effect immediately):
  - c=16'h0000 and out_valid=0.
  - Stage-1 operand registers = 0; stage-1 valid = 0.
  - Registers hold these values while rst_n is low.
- Stage 1, each rising edge with rst_n=1:
  - a_r<=a, b_r<=b, v1<=in_valid.
  - Operands are captured unconditionally; in_valid only qualifies the data.
- Combinational core, acting on a_r/b_r:
  - 2x2 cell: p0=a0&b0; p1=(a1&b0)^(a0&b1) with carry k=(a1&b0)&(a0&b1); p2=(a1&b1)^k; p3=(a1&b1)&k.
  - 4x4 block: four 2x2 cells on the operand halves, summed as lo + (mid1<<2) + (mid2<<2) + (hi<<4) with ripple/carry adders, giving an 8-bit result.
  - 8x8 block:
    - q0=aL*bL, q1=aH*bL, q2=aL*bH, q3=aH*bH (4x4 blocks; L=bits[3:0], H=bits[7:4]).
    - product[3:0]=q0[3:0].
    - temp1={4'b0,q0[7:4]}+q1 (8 bits).
    - temp2={4'b0,q2}+{q3,4'b0} (12 bits).
    - temp3={4'b0,temp1}+temp2 (12 bits).
    - product[15:4]=temp3.
  - No carry out of bit 15 is possible (max 255*255=65025).
- Stage 2, each rising edge with rst_n=1: c<=product; out_valid<=v1.
- Latency and throughput:
  - Operands sampled at edge N appear on c after edge N+1, i.e. 2 cycles after presentation.
  - Full throughput, one result per cycle; no backpressure.
- When out_valid=0, c still updates with whatever operands were captured; consumers must qualify c with out_valid.
- Reset mid-operation: all in-flight results are discarded. out_valid stays 0 until 2 edges after the first in_valid=1 following reset release.
- Fully unsigned: no sign extension, no overflow/saturation.
- Implementation is structural:
  - the 2x2 cell, 4x4 block and adders are coded as separate submodules or functions;
  - the bare `*` operator is not used in the core.

Test Plan:
- Reset: hold rst_n=0 with random a/b toggling -> c=0, out_valid=0 throughout. Deassert, then a=8'hFF, b=8'hFF, in_valid=1 -> after 2 edges c=16'hFE01 (65025), out_valid=1.
- Corners: a=0,b=0 -> 16'h0000; a=1,b=255 -> 16'h00FF; a=8'h0F,b=8'hF0 -> 16'h0E10 (3600); a=8'h80,b=8'h02 -> 16'h0100. Each result appears 2 cycles after input.
- Streaming: back-to-back in_valid=1 with pairs (3,5),(12,12),(200,7) -> consecutive cycles c=15, 144, 1400 with out_valid=1 on each.
- Bubble: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1, delayed by 2 cycles.
- Async reset mid-stream: assert rst_n=0 between edges with 2 pairs in flight -> c=0 and out_valid=0 immediately. Neither pair emerges after release.
- Exhaustive: all 65536 (a,b) pairs streamed -> each c equals a*b computed by the bench model, checked at 2-cycle offset.
